// File: rtl/vx_issue_ibuf_sb.sv
`default_nettype none
// vx_issue_ibuf_sb: per-warp instruction buffers, register scoreboard and round-robin issue.
// Optional performance counters are enabled by defining ISSUE_PERF_EN.
module vx_issue_ibuf_sb #(
    parameter int NUM_WARPS    = 4,
    parameter int IBUF_DEPTH   = 2,
    parameter int NUM_REGS     = 32,
    parameter int NUM_CHANNELS = 3,
    parameter int DATA_W       = 64,
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int RID_W = $clog2(NUM_REGS),
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    decode_valid,
    input  logic [WID_W-1:0]        decode_wid,
    input  logic [CH_W-1:0]         decode_ch,
    input  logic                    decode_wb,
    input  logic [2:0]              decode_used_rs,
    input  logic [RID_W-1:0]        decode_rd,
    input  logic [RID_W-1:0]        decode_rs1,
    input  logic [RID_W-1:0]        decode_rs2,
    input  logic [RID_W-1:0]        decode_rs3,
    input  logic [DATA_W-1:0]       decode_data,
    output logic                    decode_ready,
    input  logic                    writeback_valid,
    input  logic [WID_W-1:0]        writeback_wid,
    input  logic [RID_W-1:0]        writeback_rd,
    input  logic                    writeback_eop,
    output logic [NUM_CHANNELS-1:0] dispatch_valid,
    output logic [WID_W-1:0]        dispatch_wid,
    output logic                    dispatch_wb,
    output logic [RID_W-1:0]        dispatch_rd,
    output logic [DATA_W-1:0]       dispatch_data,
    input  logic [NUM_CHANNELS-1:0] dispatch_ready
`ifdef ISSUE_PERF_EN
    ,
    output logic [31:0]             perf_sb_stall,
    output logic [31:0]             perf_ibuf_full
`endif
);

    localparam int PTR_W = $clog2(IBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    logic [CH_W-1:0]   ch_q   [NUM_WARPS][IBUF_DEPTH];
    logic              wb_q   [NUM_WARPS][IBUF_DEPTH];
    logic [2:0]        used_q [NUM_WARPS][IBUF_DEPTH];
    logic [RID_W-1:0]  rd_q   [NUM_WARPS][IBUF_DEPTH];
    logic [RID_W-1:0]  rs1_q  [NUM_WARPS][IBUF_DEPTH];
    logic [RID_W-1:0]  rs2_q  [NUM_WARPS][IBUF_DEPTH];
    logic [RID_W-1:0]  rs3_q  [NUM_WARPS][IBUF_DEPTH];
    logic [DATA_W-1:0] data_q [NUM_WARPS][IBUF_DEPTH];

    logic [PTR_W-1:0]    rptr_q [NUM_WARPS];
    logic [PTR_W-1:0]    wptr_q [NUM_WARPS];
    logic [CNT_W-1:0]    cnt_q  [NUM_WARPS];
    logic [NUM_REGS-1:0] busy_q [NUM_WARPS];
    logic [0:0]          state_q;
    logic [WID_W-1:0]    sel_q;
    logic [WID_W-1:0]    last_q;

    logic [CH_W-1:0]   h_ch   [NUM_WARPS];
    logic              h_wb   [NUM_WARPS];
    logic [RID_W-1:0]  h_rd   [NUM_WARPS];
    logic [DATA_W-1:0] h_data [NUM_WARPS];
    logic [NUM_WARPS-1:0] w_elig;
    logic [NUM_WARPS-1:0] w_nonempty;
    logic              w_pick_vld;
    logic [WID_W-1:0]  w_pick_wid;
    logic [WID_W-1:0]  w_idx;
    logic              w_cur_vld;
    logic [WID_W-1:0]  w_cur_wid;
    logic              w_fire;
    logic              w_push;
    logic              w_set;
    logic              w_clr;

    // A head is eligible only when none of its sources and, for writers, its destination is pending.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            h_ch[w]       = ch_q[w][rptr_q[w]];
            h_wb[w]       = wb_q[w][rptr_q[w]];
            h_rd[w]       = rd_q[w][rptr_q[w]];
            h_data[w]     = data_q[w][rptr_q[w]];
            w_nonempty[w] = (cnt_q[w] != '0);
            w_elig[w]     = w_nonempty[w]
                && !(used_q[w][rptr_q[w]][0] && busy_q[w][rs1_q[w][rptr_q[w]]])
                && !(used_q[w][rptr_q[w]][1] && busy_q[w][rs2_q[w][rptr_q[w]]])
                && !(used_q[w][rptr_q[w]][2] && busy_q[w][rs3_q[w][rptr_q[w]]])
                && !(h_wb[w] && busy_q[w][h_rd[w]]);
        end
    end

    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_wid = '0;
        w_idx      = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            w_idx = WID_W'((int'(last_q) + 1 + i) % NUM_WARPS);
            if (!w_pick_vld && w_elig[w_idx]) begin
                w_pick_vld = 1'b1;
                w_pick_wid = w_idx;
            end
        end
    end

    // A pending offer stays locked to its warp until it fires.
    assign w_cur_vld = (state_q == ST_OFFER) ? 1'b1  : w_pick_vld;
    assign w_cur_wid = (state_q == ST_OFFER) ? sel_q : w_pick_wid;

    assign dispatch_valid = w_cur_vld ? (NUM_CHANNELS'(1) << h_ch[w_cur_wid]) : '0;
    assign dispatch_wid   = w_cur_vld ? w_cur_wid         : '0;
    assign dispatch_wb    = w_cur_vld ? h_wb[w_cur_wid]   : 1'b0;
    assign dispatch_rd    = w_cur_vld ? h_rd[w_cur_wid]   : '0;
    assign dispatch_data  = w_cur_vld ? h_data[w_cur_wid] : '0;

    assign w_fire       = |(dispatch_valid & dispatch_ready);
    assign decode_ready = (cnt_q[decode_wid] < CNT_W'(IBUF_DEPTH));
    assign w_push       = decode_valid && decode_ready;
    assign w_set        = w_fire && h_wb[w_cur_wid] && (h_rd[w_cur_wid] != '0);
    assign w_clr        = writeback_valid && writeback_eop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            ch_q[decode_wid][wptr_q[decode_wid]]   <= decode_ch;
            wb_q[decode_wid][wptr_q[decode_wid]]   <= decode_wb;
            used_q[decode_wid][wptr_q[decode_wid]] <= decode_used_rs;
            rd_q[decode_wid][wptr_q[decode_wid]]   <= decode_rd;
            rs1_q[decode_wid][wptr_q[decode_wid]]  <= decode_rs1;
            rs2_q[decode_wid][wptr_q[decode_wid]]  <= decode_rs2;
            rs3_q[decode_wid][wptr_q[decode_wid]]  <= decode_rs3;
            data_q[decode_wid][wptr_q[decode_wid]] <= decode_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                rptr_q[w] <= '0;
                wptr_q[w] <= '0;
                cnt_q[w]  <= '0;
                busy_q[w] <= '0;
            end
            state_q <= ST_IDLE;
            sel_q   <= '0;
            last_q  <= WID_W'(NUM_WARPS - 1);
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (w_push && (decode_wid == WID_W'(w)))
                    wptr_q[w] <= wptr_q[w] + PTR_W'(1);
                if (w_fire && (w_cur_wid == WID_W'(w)))
                    rptr_q[w] <= rptr_q[w] + PTR_W'(1);
                case ({w_push && (decode_wid == WID_W'(w)), w_fire && (w_cur_wid == WID_W'(w))})
                    2'b10:   cnt_q[w] <= cnt_q[w] + CNT_W'(1);
                    2'b01:   cnt_q[w] <= cnt_q[w] - CNT_W'(1);
                    default: cnt_q[w] <= cnt_q[w];
                endcase
            end
            if (w_set)
                busy_q[w_cur_wid][h_rd[w_cur_wid]] <= 1'b1;
            if (w_clr)
                busy_q[writeback_wid][writeback_rd] <= 1'b0;
            if (w_cur_vld && !w_fire) begin
                state_q <= ST_OFFER;
                sel_q   <= w_cur_wid;
            end else begin
                state_q <= ST_IDLE;
            end
            if (w_fire)
                last_q <= w_cur_wid;
        end
    end

    a_no_set_clr_same: assert property (@(posedge clk) disable iff (!reset_n)
        !(w_set && w_clr && (w_cur_wid == writeback_wid) && (h_rd[w_cur_wid] == writeback_rd)));
    a_clr_only_busy: assert property (@(posedge clk) disable iff (!reset_n)
        w_clr |-> busy_q[writeback_wid][writeback_rd]);

`ifdef ISSUE_PERF_EN
    logic [31:0] perf_sb_stall_q;
    logic [31:0] perf_ibuf_full_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_sb_stall_q  <= '0;
            perf_ibuf_full_q <= '0;
        end else begin
            if ((|w_nonempty) && !(|w_elig) && (perf_sb_stall_q != '1))
                perf_sb_stall_q <= perf_sb_stall_q + 32'd1;
            if (decode_valid && !decode_ready && (perf_ibuf_full_q != '1))
                perf_ibuf_full_q <= perf_ibuf_full_q + 32'd1;
        end
    end

    assign perf_sb_stall  = perf_sb_stall_q;
    assign perf_ibuf_full = perf_ibuf_full_q;
`endif

endmodule
`default_nettype wire

// File: doc/vx_issue_ibuf_sb.md
# vx_issue_ibuf_sb

Parametrised issue stage: per-warp instruction buffers, a per-warp register scoreboard and a round-robin warp selector feeding NUM_CHANNELS execute channels. It sits between decode and the execute-unit dispatch ports in the core pipeline, generalising the fixed single-slice issue wrapper to configurable warp count, buffer depth, register count and channel count.

## Interface
- NUM_WARPS, 4: warps tracked; WID_W = max(1, clog2(NUM_WARPS)).
- IBUF_DEPTH, 2: entries per warp buffer; power of 2, ≥ 2.
- NUM_REGS, 32: registers per warp; RID_W = clog2(NUM_REGS).
- NUM_CHANNELS, 3: execute channels; CH_W = max(1, clog2(NUM_CHANNELS)).
- DATA_W, 64: opaque payload width (uuid, PC, op fields).

- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- decode_valid  in  1  decode entry valid.
- decode_wid  in  WID_W  warp id.
- decode_ch  in  CH_W  target channel.
- decode_wb  in  1  writes rd.
- decode_used_rs  in  3  rs1/rs2/rs3 used mask.
- decode_rd, decode_rs1, decode_rs2, decode_rs3  in  RID_W each  register indices.
- decode_data  in  DATA_W  payload.
- decode_ready  out  1  buffer of decode_wid not full.
- writeback_valid  in  1  writeback beat.
- writeback_wid  in  WID_W, writeback_rd  in  RID_W, writeback_eop  in  1  last beat.
- dispatch_valid  out  NUM_CHANNELS  one-hot channel valid.
- dispatch_wid  out  WID_W; dispatch_wb  out  1; dispatch_rd  out  RID_W; dispatch_data  out  DATA_W  shared payload.
- dispatch_ready  in  NUM_CHANNELS  per-channel ready.

## Operation
- Per-warp FIFO of IBUF_DEPTH entries; stores ch, wb, used_rs, rd, rs1–3, data. Decode fires on decode_valid && decode_ready; decode_ready = count[decode_wid] < IBUF_DEPTH (no pop-through on full).
- Scoreboard: NUM_WARPS×NUM_REGS busy bits. Set at dispatch fire when wb=1 and rd≠0. Cleared on writeback_valid && writeback_eop for (writeback_wid, writeback_rd). Register 0 is never busy.
- Head of warp w eligible: buffer non-empty, no used rs busy, and rd not busy if wb=1 (RAW + WAW).
- Selector: round-robin over eligible warps, search starting at last_issued+1 mod NUM_WARPS.
- States: IDLE (no selection) → OFFER (selected warp head driven; dispatch_valid[head.ch]=1). OFFER→IDLE on fire (dispatch_valid[c] && dispatch_ready[c]); pop head, update scoreboard, last_issued=w. OFFER with no fire: selection locked, payload stable. OFFER→OFFER on fire when another head is eligible the following cycle.
- Set and clear of the same bit in one cycle cannot occur (dispatch requires not busy); assertion fires if it does. Writeback clearing a non-busy bit: assertion, no state change.
- Reset: all FIFOs empty, scoreboard clear, last_issued=NUM_WARPS-1, state IDLE; outputs dispatch_valid=0, dispatch_wid/wb/rd/data=0, decode_ready=1.

## Timing
- Decode accepted at edge t → earliest dispatch_valid in cycle t+1; no same-cycle bypass.
- Writeback clear at edge t → dependent head eligible in cycle t+1.
- Full throughput: one dispatch per cycle when heads eligible and ready high.
- dispatch_valid never deasserts without fire; payload constant while valid && !ready.
- Simultaneous decode push and dispatch pop on the same warp permitted; count unchanged.
- reset_n assertion mid-operation clears everything asynchronously; in-flight offer dropped.

## Configuration
- ISSUE_PERF_EN defined: adds outputs perf_sb_stall (32, cycles with ≥1 non-empty buffer but no eligible head) and perf_ibuf_full (32, cycles decode_valid && !decode_ready); saturating, cleared by reset.
- Undefined: ports and counters absent; no other behavioural change.

## Test plan
- Reset then decode wid=0, ch=1, rd=5, wb=1 → dispatch_valid=3'b010 next cycle; after fire busy[0][5]=1.
- Dependent rs1=5 on wid=0 → held until writeback wid=0, rd=5, eop=1; dispatches the cycle after.
- Warps 0..3 each one entry, all ready → dispatch order 0,1,2,3 in four consecutive cycles; after issuing warp 2, warp 3 then 0 are preferred.
- dispatch_ready[1]=0 for 5 cycles with offer pending → dispatch_valid and payload stable; fire on cycle 6.
- Fill wid=1 with IBUF_DEPTH=2 entries → decode_ready=0 for wid=1, 1 for wid=2; perf_ibuf_full increments when ISSUE_PERF_EN.
- reset_n low mid-offer with busy bits set → all outputs zero, scoreboard clear, decode_ready=1 after release.
